// File: rtl/common_pkg.sv
// Shared FP51 constants and types; the timebase generator's defaults and the
// channel run-state enum live here.
package common_pkg;

    localparam int TIMER_UNIT_CLASSIC_PULSE_PERIOD = 96;
    localparam int MAX_UART_BAID_PERIOD            = 10000;

    localparam int TIMEBASE_NUM_CH       = 4;
    localparam int TIMEBASE_PERIOD_WIDTH = 16;
    localparam int TIMEBASE_MIN_PERIOD   = 4;
    localparam int TIMEBASE_MAX_PERIOD   = MAX_UART_BAID_PERIOD;

    typedef logic unsigned [TIMEBASE_PERIOD_WIDTH-1:0] timebase_period_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/timebase_gen_if.sv
// Bus between the SFR write side / timer consumers and the timebase generator.
interface timebase_gen_if
    import common_pkg::*;
#(
    parameter int NUM_CH       = TIMEBASE_NUM_CH,
    parameter int PERIOD_WIDTH = TIMEBASE_PERIOD_WIDTH
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       ch_en;
    logic                    restart;
    logic                    we;
    logic [SEL_W-1:0]        ch_sel;
    logic [PERIOD_WIDTH-1:0] wdata;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       mid_tick;
    logic                    wr_err;
    logic [PERIOD_WIDTH-1:0] period_rd;

    modport master (
        output ch_en, restart, we, ch_sel, wdata,
        input  tick, mid_tick, wr_err, period_rd
    );

    modport slave (
        input  ch_en, restart, we, ch_sel, wdata,
        output tick, mid_tick, wr_err, period_rd
    );

endinterface

// File: rtl/timebase_channel.sv
// One timebase channel: period counter with active/shadow period registers,
// wrap and half-period detection, registered tick outputs.
module timebase_channel
    import common_pkg::*;
#(
    parameter int PERIOD_WIDTH   = TIMEBASE_PERIOD_WIDTH,
    parameter int DEFAULT_PERIOD = TIMER_UNIT_CLASSIC_PULSE_PERIOD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    restart,
    input  logic                    wr,
    input  logic [PERIOD_WIDTH-1:0] wdata,
    output logic                    tick,
    output logic                    mid_tick,
    output logic [PERIOD_WIDTH-1:0] active
);
    typedef logic [PERIOD_WIDTH-1:0] per_t;

    ch_state_e state, state_nx;
    per_t      cnt, cnt_nx, active_nx, shadow, shadow_nx, upd;
    logic      wrap, mid, tick_nx, mid_nx;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        active_nx = active;
        tick_nx   = 1'b0;
        mid_nx    = 1'b0;
        // a write landing on a reload cycle goes straight into active
        upd       = wr ? wdata : shadow;
        shadow_nx = upd;
        wrap      = (cnt == active - per_t'(1));
        mid       = (cnt == (active >> 1) - per_t'(1));
        case (state)
            CH_IDLE: begin
                cnt_nx    = '0;
                active_nx = upd;
                if (en) state_nx = CH_RUN;
            end
            CH_RUN: begin
                if (!en) begin
                    state_nx  = CH_IDLE;
                    cnt_nx    = '0;
                    active_nx = upd;
                end else begin
                    tick_nx = wrap;
                    mid_nx  = mid;
                    if (wrap || restart) begin
                        cnt_nx    = '0;
                        active_nx = upd;
                    end else begin
                        cnt_nx = cnt + per_t'(1);
                    end
                end
            end
            default: state_nx = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CH_IDLE;
            cnt      <= '0;
            active   <= per_t'(DEFAULT_PERIOD);
            shadow   <= per_t'(DEFAULT_PERIOD);
            tick     <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            active   <= active_nx;
            shadow   <= shadow_nx;
            tick     <= tick_nx;
            mid_tick <= mid_nx;
        end
    end

endmodule

// File: rtl/timebase_gen.sv
// Multi-channel programmable timebase: clamps period writes, decodes the
// target channel and reads back the selected channel's active period.
module timebase_gen
    import common_pkg::*;
#(
    parameter int NUM_CH         = TIMEBASE_NUM_CH,
    parameter int PERIOD_WIDTH   = TIMEBASE_PERIOD_WIDTH,
    parameter int MIN_PERIOD     = TIMEBASE_MIN_PERIOD,
    parameter int MAX_PERIOD     = TIMEBASE_MAX_PERIOD,
    parameter int DEFAULT_PERIOD = TIMER_UNIT_CLASSIC_PULSE_PERIOD
) (
    input logic           clk,
    input logic           reset,
    timebase_gen_if.slave bus
);
    typedef logic [PERIOD_WIDTH-1:0] per_t;

    localparam per_t MIN_P = per_t'(MIN_PERIOD);
    localparam per_t MAX_P = per_t'(MAX_PERIOD);

    per_t                          clamped, rd_mux;
    logic                          ch_ok;
    logic [NUM_CH-1:0]             wr_v, tick_v, mid_v;
    logic [NUM_CH-1:0][PERIOD_WIDTH-1:0] active_v;

    always_comb begin
        if (bus.wdata < MIN_P)      clamped = MIN_P;
        else if (bus.wdata > MAX_P) clamped = MAX_P;
        else                        clamped = bus.wdata;
    end

    assign ch_ok = (32'(bus.ch_sel) < NUM_CH);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (32'(bus.ch_sel) == i) rd_mux = active_v[i];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_v[i] = bus.we && (32'(bus.ch_sel) == i);

        timebase_channel #(
            .PERIOD_WIDTH   (PERIOD_WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (bus.ch_en[i]),
            .restart  (bus.restart),
            .wr       (wr_v[i]),
            .wdata    (clamped),
            .tick     (tick_v[i]),
            .mid_tick (mid_v[i]),
            .active   (active_v[i])
        );
    end

    assign bus.tick     = tick_v;
    assign bus.mid_tick = mid_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.wr_err    <= 1'b0;
            bus.period_rd <= per_t'(DEFAULT_PERIOD);
        end else begin
            bus.wr_err    <= bus.we && ((clamped != bus.wdata) || !ch_ok);
            bus.period_rd <= rd_mux;
        end
    end

endmodule
